ddr3_ui_bram_emu: RTL
=====================

DDR3_UI_BRAM_EMU -- requirements
Module: ddr3_ui_bram_emu

Interface
REQ-001 Parameter ADDR_BITS, default 10, number of on-chip memory word-index bits (1024 x 128-bit words, 4 pages).
REQ-002 Parameter RD_LATENCY, default 8, cycles from read-command execution to read-data valid; legal range 2..32.
REQ-003 Parameter FIFO_DEPTH, default 4, depth of both the command FIFO and the write-data FIFO; power of two, at least 2.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 app_addr  in  28  UI address; bits [2:0] ignored; word index = app_addr[ADDR_BITS+2:3].
REQ-007 app_en  in  1  command valid.
REQ-008 app_cmd  in  3  command code: 0 = write, 1 = read, any other value is illegal.
REQ-009 app_wdf_data  in  128  write data.
REQ-010 app_wdf_wren  in  1  write-data valid.
REQ-011 app_wdf_end  in  1  last beat of a burst; must equal app_wdf_wren.
REQ-012 app_rdy  out  1  command accepted this cycle when app_rdy and app_en are both high.
REQ-013 app_wdf_rdy  out  1  data accepted this cycle when app_wdf_rdy and app_wdf_wren are both high.
REQ-014 app_rd_data_valid  out  1  app_rd_data is valid this cycle.
REQ-015 app_rd_data  out  128  read data.
REQ-016 proto_err  out  1  sticky protocol-error flag.

Function
REQ-017 The block SHALL emulate the DDR3 memory-interface UI as the responder, backed by a 2^ADDR_BITS x 128 RAM.
REQ-018 Accepted commands SHALL enter the command FIFO (address, cmd); accepted data SHALL enter the write-data FIFO.
REQ-019 app_rdy SHALL be high only when the command FIFO count < FIFO_DEPTH; app_wdf_rdy SHALL be high only when the data FIFO count < FIFO_DEPTH; both are driven from registered state only.
REQ-020 Write data may arrive before, with, or after its command; pairing SHALL be strictly in order.
REQ-021 Execution SHALL complete at most one command per cycle, strictly in FIFO order.
- Read at head: pop and execute the same cycle.
- Write at head: pop and execute only when the data FIFO is non-empty, popping both together.
- Write at head with the data FIFO empty: stall the head.
REQ-022 A write SHALL update the RAM at the word index; the data is visible to any read executed in a later cycle.
REQ-023 A read executed at cycle E SHALL assert app_rd_data_valid for exactly one cycle at E+RD_LATENCY, with the RAM word; the latency is a shift pipeline, and reads return in order.
REQ-024 Timing for an empty command FIFO: command accepted at edge T executes at T+1, so read data is valid at T+1+RD_LATENCY.
REQ-025 Simultaneous push and pop on a FIFO SHALL leave its count unchanged; a push to a full FIFO cannot occur because rdy is low.
REQ-026 Address bits above ADDR_BITS+2 SHALL be ignored, so addresses alias and the index wraps modulo 2^ADDR_BITS.
REQ-027 An illegal app_cmd SHALL be accepted and then discarded at execution without RAM access, and SHALL set proto_err.
REQ-028 app_wdf_wren != app_wdf_end in any cycle SHALL set proto_err; the beat is still accepted per REQ-013.
REQ-029 proto_err SHALL clear only on rst.

Reset
REQ-030 While rst is high, all outputs SHALL be 0: app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data, and proto_err.
REQ-031 Reset SHALL empty both FIFOs and clear the read pipeline, discarding in-flight reads with no valid pulse; RAM contents SHALL be retained.
REQ-032 app_rdy and app_wdf_rdy SHALL be high in the first cycle after rst deasserts.

Configuration
REQ-033 Macro DDR3_EMU_BACKPRESSURE_EN defined: the block SHALL apply synthetic stalls in addition to REQ-019.
- A free-running 2-bit counter forces app_rdy low whenever the count is 3.
- A free-running mod-5 counter forces app_wdf_rdy low whenever the count is 4.
- Both counters reset to 0.
REQ-034 Macro DDR3_EMU_BACKPRESSURE_EN undefined: rdy outputs SHALL depend only on FIFO fullness and reset.

Structure
REQ-035 Package ddr3_ui_pkg SHALL hold the following shared definitions:
- APP_CMD_WRITE = 0 and APP_CMD_RD = 1.
- UI address width 28 and data width 128.
- The words-per-burst address stride 8.
REQ-036 One sub-module, ddr3_emu_fifo (synchronous FIFO, parameterized width and depth, with count output), SHALL be instantiated twice.

Verification
REQ-037 Write 256 bursts to addr 0x0000000..0x00007F8, data = index, then read them back -> 256 valid beats, in order, data 0..255, no proto_err.
REQ-038 Single read to addr 0x40, RD_LATENCY 8, idle FIFOs, accepted at cycle 10 -> app_rd_data_valid high only in cycle 19.
REQ-039 Present four data beats with no commands, then a fifth -> app_wdf_rdy low on the fifth; four write commands then drain the data FIFO and app_wdf_rdy returns high.
REQ-040 Write 0xAA to addr 0x2000 (ADDR_BITS 10), then read addr 0x0 -> data 0xAA (alias).
REQ-041 app_cmd = 3 accepted -> no RAM change, no read pulse, proto_err = 1 until rst.
REQ-042 With DDR3_EMU_BACKPRESSURE_EN defined, run the scenario of REQ-037 -> app_rdy low every fourth cycle, identical data returned; assert rst with reads in flight -> no further valid pulses.

Source files
------------

// File: rtl/ddr3_ui_pkg.sv
// Shared definitions for the DDR3 UI block-RAM emulator: UI widths,
// command codes, burst address stride and the execution-op encoding.
package ddr3_ui_pkg;

    localparam int APP_ADDR_W   = 28;
    localparam int APP_DATA_W   = 128;
    localparam int APP_CMD_W    = 3;
    localparam int BURST_STRIDE = 8;

    localparam logic [APP_CMD_W-1:0] APP_CMD_WRITE = 3'd0;
    localparam logic [APP_CMD_W-1:0] APP_CMD_RD    = 3'd1;

    // What the execution stage does with the command FIFO head this cycle
    typedef enum logic [1:0] {
        EXEC_IDLE,
        EXEC_RD,
        EXEC_WR,
        EXEC_DROP
    } exec_op_e;

endpackage

// File: rtl/ddr3_ui_bram_emu_if.sv
// DDR3 UI application-side signal bundle. The master modport is the
// application (traffic source); the slave modport is the memory emulator.
interface ddr3_ui_bram_emu_if;
    import ddr3_ui_pkg::*;

    logic [APP_ADDR_W-1:0] app_addr;
    logic                  app_en;
    logic [APP_CMD_W-1:0]  app_cmd;
    logic [APP_DATA_W-1:0] app_wdf_data;
    logic                  app_wdf_wren;
    logic                  app_wdf_end;
    logic                  app_rdy;
    logic                  app_wdf_rdy;
    logic                  app_rd_data_valid;
    logic [APP_DATA_W-1:0] app_rd_data;
    logic                  proto_err;

    modport master (
        output app_addr, app_en, app_cmd, app_wdf_data, app_wdf_wren, app_wdf_end,
        input  app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data, proto_err
    );

    modport slave (
        input  app_addr, app_en, app_cmd, app_wdf_data, app_wdf_wren, app_wdf_end,
        output app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data, proto_err
    );

endinterface

// File: rtl/ddr3_emu_fifo.sv
// Synchronous FIFO with occupancy count. Head data is shown combinationally
// (first-word fall-through). Push when full and pop when empty are ignored.
module ddr3_emu_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Next pointer and occupancy; simultaneous push/pop keeps the count
    always_comb begin
        do_push  = push && (count_q < CNT_W'(DEPTH));
        do_pop   = pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign empty     = (count_q == '0);

endmodule

// File: rtl/ddr3_ui_bram_emu.sv
// DDR3 memory-interface UI responder backed by on-chip RAM.
// Commands and write data queue in separate FIFOs and pair strictly in
// order; reads return through a fixed-latency shift pipeline.
// Optional build macro: DDR3_EMU_BACKPRESSURE_EN adds synthetic stalls on
// app_rdy (every 4th cycle) and app_wdf_rdy (every 5th cycle).
module ddr3_ui_bram_emu
    import ddr3_ui_pkg::*;
#(
    parameter int ADDR_BITS  = 10,
    parameter int RD_LATENCY = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    ddr3_ui_bram_emu_if.slave   ui
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int CMD_FW = ADDR_BITS + APP_CMD_W;

    // Command FIFO entries carry only the word index and the command code
    logic [CMD_FW-1:0]     cmd_push_data, cmd_head;
    logic [ADDR_BITS-1:0]  cmd_head_idx;
    logic [APP_CMD_W-1:0]  cmd_head_cmd;
    logic                  cmd_push, cmd_pop, cmd_empty;
    logic [CNT_W-1:0]      cmd_count;

    logic [APP_DATA_W-1:0] dat_head;
    logic                  dat_push, dat_pop, dat_empty;
    logic [CNT_W-1:0]      dat_count;

    logic                  cmd_stall, dat_stall;
    exec_op_e              exec_op;

    logic [APP_DATA_W-1:0] ram_q [2**ADDR_BITS];

    logic [RD_LATENCY-1:0] rd_vld_q, rd_vld_d;
    logic [APP_DATA_W-1:0] rd_dat_q [RD_LATENCY];
    logic [APP_DATA_W-1:0] rd_dat_d [RD_LATENCY];

    logic                  proto_err_q, proto_err_d;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^{ui.app_addr[APP_ADDR_W-1:ADDR_BITS+3], ui.app_addr[2:0]};

    assign cmd_push_data = {ui.app_addr[ADDR_BITS+2:3], ui.app_cmd};
    assign cmd_head_idx  = cmd_head[CMD_FW-1:APP_CMD_W];
    assign cmd_head_cmd  = cmd_head[APP_CMD_W-1:0];

    assign cmd_push = ui.app_en && ui.app_rdy;
    assign dat_push = ui.app_wdf_wren && ui.app_wdf_rdy;

    ddr3_emu_fifo #(.WIDTH(CMD_FW), .DEPTH(FIFO_DEPTH)) u_cmd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_push),
        .push_data (cmd_push_data),
        .pop       (cmd_pop),
        .head_data (cmd_head),
        .count     (cmd_count),
        .empty     (cmd_empty)
    );

    ddr3_emu_fifo #(.WIDTH(APP_DATA_W), .DEPTH(FIFO_DEPTH)) u_dat_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (dat_push),
        .push_data (ui.app_wdf_data),
        .pop       (dat_pop),
        .head_data (dat_head),
        .count     (dat_count),
        .empty     (dat_empty)
    );

`ifdef DDR3_EMU_BACKPRESSURE_EN
    logic [1:0] bp_cmd_cnt_q, bp_cmd_cnt_d;
    logic [2:0] bp_dat_cnt_q, bp_dat_cnt_d;

    // Free-running stall counters: mod-4 for commands, mod-5 for data
    always_comb begin
        bp_cmd_cnt_d = bp_cmd_cnt_q + 2'd1;
        bp_dat_cnt_d = (bp_dat_cnt_q == 3'd4) ? 3'd0 : bp_dat_cnt_q + 3'd1;
    end

    // Stall counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            bp_cmd_cnt_q <= '0;
            bp_dat_cnt_q <= '0;
        end else begin
            bp_cmd_cnt_q <= bp_cmd_cnt_d;
            bp_dat_cnt_q <= bp_dat_cnt_d;
        end
    end

    assign cmd_stall = (bp_cmd_cnt_q == 2'd3);
    assign dat_stall = (bp_dat_cnt_q == 3'd4);
`else
    assign cmd_stall = 1'b0;
    assign dat_stall = 1'b0;
`endif

    // Execution decode: a write at the head waits for its data beat
    always_comb begin
        exec_op = EXEC_IDLE;
        if (!rst && !cmd_empty) begin
            if (cmd_head_cmd == APP_CMD_RD) begin
                exec_op = EXEC_RD;
            end else if (cmd_head_cmd == APP_CMD_WRITE) begin
                if (!dat_empty) exec_op = EXEC_WR;
            end else begin
                exec_op = EXEC_DROP;
            end
        end
        cmd_pop = (exec_op != EXEC_IDLE);
        dat_pop = (exec_op == EXEC_WR);
    end

    // RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (exec_op == EXEC_WR) ram_q[cmd_head_idx] <= dat_head;
    end

    // Read pipeline shift: stage 0 captures the RAM word at execution
    always_comb begin
        rd_vld_d    = {rd_vld_q[RD_LATENCY-2:0], exec_op == EXEC_RD};
        rd_dat_d[0] = ram_q[cmd_head_idx];
        for (int i = 1; i < RD_LATENCY; i++) rd_dat_d[i] = rd_dat_q[i-1];
    end

    // Read valid pipeline; reset drops reads in flight
    always_ff @(posedge clk) begin
        if (rst) rd_vld_q <= '0;
        else     rd_vld_q <= rd_vld_d;
    end

    // Read data pipeline; qualified by rd_vld_q so no reset needed
    always_ff @(posedge clk) begin
        for (int i = 0; i < RD_LATENCY; i++) rd_dat_q[i] <= rd_dat_d[i];
    end

    // Sticky protocol error: dropped illegal command or wren/end mismatch
    always_comb begin
        proto_err_d = proto_err_q || (exec_op == EXEC_DROP) ||
                      (ui.app_wdf_wren != ui.app_wdf_end);
    end

    // Protocol error register
    always_ff @(posedge clk) begin
        if (rst) proto_err_q <= 1'b0;
        else     proto_err_q <= proto_err_d;
    end

    // Outputs are forced low while rst is held so they are clean from the
    // first reset cycle and return immediately once rst drops.
    assign ui.app_rdy           = !rst && !cmd_stall && (cmd_count < CNT_W'(FIFO_DEPTH));
    assign ui.app_wdf_rdy       = !rst && !dat_stall && (dat_count < CNT_W'(FIFO_DEPTH));
    assign ui.app_rd_data_valid = !rst && rd_vld_q[RD_LATENCY-1];
    assign ui.app_rd_data       = ui.app_rd_data_valid ? rd_dat_q[RD_LATENCY-1] : '0;
    assign ui.proto_err         = !rst && proto_err_q;

endmodule
